// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: two-entry (main + skid) buffer with flush, gated
// register-file write enable, writeback data select and a retired-beat counter.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              M_Valid,
    output logic              M_Ready,
    input  logic [DATA_W-1:0] M_Dout,
    input  logic [DATA_W-1:0] M_ALUout,
    input  logic              M_Overflow,
    input  logic [REG_AW-1:0] M_Rw,
    input  logic              M_RegWr,
    input  logic              M_MemtoReg,
    input  logic              W_Stall,
    output logic              W_Valid,
    output logic [DATA_W-1:0] W_Dout,
    output logic [DATA_W-1:0] W_ALUout,
    output logic              W_Overflow,
    output logic              W_RegWr,
    output logic              W_MemtoReg,
    output logic [REG_AW-1:0] W_Rw,
    output logic [DATA_W-1:0] W_WrData,
    output logic              W_WrEn,
    output logic [CNT_W-1:0]  W_RetireCnt
);

    localparam int ENT_W = 2 * DATA_W + REG_AW + 3;

    // Handshake: a beat moves upstream->stage when M_Valid & M_Ready on a falling
    // edge, and stage->writeback when W_Valid & ~W_Stall. M_Ready is registered
    // (NOT skid valid) so W_Stall never reaches it combinationally.

    logic [ENT_W-1:0] main_q, main_d;
    logic [ENT_W-1:0] skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ENT_W-1:0] in_beat;
    logic             accept;
    logic             consume;

    assign in_beat = {M_Dout, M_ALUout, M_Overflow, M_Rw, M_RegWr, M_MemtoReg};
    assign M_Ready = ~skid_valid_q;
    assign W_Valid = main_valid_q;
    assign accept  = M_Valid & M_Ready;
    assign consume = main_valid_q & ~W_Stall;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;
        if (Flush) begin
            main_d       = '0;
            skid_d       = '0;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (!main_valid_q) begin
                if (accept) begin
                    main_d       = in_beat;
                    main_valid_d = 1'b1;
                end
            end else if (consume) begin
                // Skid entry is always older than any incoming beat.
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    main_d = in_beat;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_d       = in_beat;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign {W_Dout, W_ALUout, W_Overflow, W_Rw, W_RegWr, W_MemtoReg} = main_q;

    assign W_WrData    = W_MemtoReg ? W_Dout : W_ALUout;
    assign W_WrEn      = main_valid_q & W_RegWr & ~W_Overflow & (W_Rw != '0);
    assign W_RetireCnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Randomised + directed bench for mem_wb_pipe against a queue-based model of
// the stage (up to two beats in flight, FIFO order, counted retirements).
module tb_mem_wb_pipe;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;
    localparam int BW     = 2 * DATA_W + REG_AW + 3;

    logic              Clk = 1'b0;
    logic              Reset, Flush, M_Valid, M_Overflow, M_RegWr, M_MemtoReg, W_Stall;
    logic [DATA_W-1:0] M_Dout, M_ALUout;
    logic [REG_AW-1:0] M_Rw;
    logic              M_Ready, W_Valid, W_Overflow, W_RegWr, W_MemtoReg, W_WrEn;
    logic [DATA_W-1:0] W_Dout, W_ALUout, W_WrData;
    logic [REG_AW-1:0] W_Rw;
    logic [CNT_W-1:0]  W_RetireCnt;

    logic              s_m_ready, s_w_valid, s_w_overflow, s_w_regwr, s_w_memtoreg, s_w_wren;
    logic [DATA_W-1:0] s_w_dout, s_w_aluout, s_w_wrdata;
    logic [REG_AW-1:0] s_w_rw;
    logic [3:0]        s_w_cnt;

    logic [BW-1:0] exp_q[$];
    int unsigned   exp_cnt;
    int            checks = 0;
    int            errors = 0;
    int unsigned   base_cnt;

    mem_wb_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .M_Valid(M_Valid), .M_Ready(M_Ready),
        .M_Dout(M_Dout), .M_ALUout(M_ALUout), .M_Overflow(M_Overflow), .M_Rw(M_Rw),
        .M_RegWr(M_RegWr), .M_MemtoReg(M_MemtoReg), .W_Stall(W_Stall), .W_Valid(W_Valid),
        .W_Dout(W_Dout), .W_ALUout(W_ALUout), .W_Overflow(W_Overflow), .W_RegWr(W_RegWr),
        .W_MemtoReg(W_MemtoReg), .W_Rw(W_Rw), .W_WrData(W_WrData), .W_WrEn(W_WrEn),
        .W_RetireCnt(W_RetireCnt)
    );

    // Narrow-counter instance sharing all inputs, used for the wrap check.
    mem_wb_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(4)) dut_small (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .M_Valid(M_Valid), .M_Ready(s_m_ready),
        .M_Dout(M_Dout), .M_ALUout(M_ALUout), .M_Overflow(M_Overflow), .M_Rw(M_Rw),
        .M_RegWr(M_RegWr), .M_MemtoReg(M_MemtoReg), .W_Stall(W_Stall), .W_Valid(s_w_valid),
        .W_Dout(s_w_dout), .W_ALUout(s_w_aluout), .W_Overflow(s_w_overflow), .W_RegWr(s_w_regwr),
        .W_MemtoReg(s_w_memtoreg), .W_Rw(s_w_rw), .W_WrData(s_w_wrdata), .W_WrEn(s_w_wren),
        .W_RetireCnt(s_w_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] dout, input logic [DATA_W-1:0] alu,
                         input logic ovf, input logic [REG_AW-1:0] rw, input logic regwr,
                         input logic m2r);
        M_Valid = v; M_Dout = dout; M_ALUout = alu; M_Overflow = ovf;
        M_Rw = rw; M_RegWr = regwr; M_MemtoReg = m2r;
    endtask

    task automatic check_outputs();
        logic [BW-1:0]     h;
        logic [DATA_W-1:0] e_dout, e_alu;
        logic [REG_AW-1:0] e_rw;
        logic              e_ovf, e_regwr, e_m2r;
        check("w_valid", W_Valid, exp_q.size() > 0);
        check("m_ready", M_Ready, exp_q.size() < 2);
        check("retire_cnt", W_RetireCnt, exp_cnt % (1 << CNT_W));
        check("retire_cnt4", s_w_cnt, exp_cnt % 16);
        check("w_valid_small", s_w_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            h      = exp_q[0];
            e_dout = h[BW-1 -: DATA_W];
            e_alu  = h[BW-1-DATA_W -: DATA_W];
            e_ovf  = h[REG_AW+2];
            e_rw   = h[REG_AW+1:2];
            e_regwr = h[1];
            e_m2r  = h[0];
            check("w_fields", {W_Dout, W_ALUout, W_Overflow, W_Rw, W_RegWr, W_MemtoReg}, h);
            check("w_wrdata", W_WrData, e_m2r ? e_dout : e_alu);
            check("w_wren", W_WrEn, e_regwr && !e_ovf && (e_rw != 0));
        end else begin
            check("w_wren_idle", W_WrEn, 1'b0);
        end
    endtask

    // One falling edge: advance the model with the inputs as driven, then check.
    task automatic step();
        logic cons, acc;
        @(negedge Clk);
        if (Reset) begin
            exp_q.delete();
            exp_cnt = 0;
        end else if (Flush) begin
            exp_q.delete();
        end else begin
            cons = (exp_q.size() > 0) && !W_Stall;
            acc  = M_Valid && (exp_q.size() < 2);
            if (cons) begin
                void'(exp_q.pop_front());
                exp_cnt++;
            end
            if (acc) exp_q.push_back({M_Dout, M_ALUout, M_Overflow, M_Rw, M_RegWr, M_MemtoReg});
        end
        #2;
        check_outputs();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, W_Valid, 1'b0);
        check({tag, "_ready"}, M_Ready, 1'b1);
        check({tag, "_wren"}, W_WrEn, 1'b0);
        check({tag, "_fields"}, {W_Dout, W_ALUout, W_Overflow, W_Rw, W_RegWr, W_MemtoReg}, '0);
        check({tag, "_wrdata"}, W_WrData, '0);
        check({tag, "_cnt"}, W_RetireCnt, '0);
    endtask

    initial begin
        Reset = 1'b1; Flush = 1'b0; W_Stall = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        Reset = 1'b0;
        check_reset_state("init_reset");

        // Streaming 1..4
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, '0, DATA_W'(k), 1'b0, 5'd3, 1'b1, 1'b0);
            step();
            check("stream_wrdata", W_WrData, DATA_W'(k));
            check("stream_wren", W_WrEn, 1'b1);
        end
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        step();
        check("stream_cnt", W_RetireCnt, 16'd4);

        // Write-enable gating
        base_cnt = W_RetireCnt;
        drive(1'b1, '0, 32'h7, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        check("gate_rw0", W_WrEn, 1'b0);
        drive(1'b1, '0, 32'h8, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        check("gate_ovf", W_WrEn, 1'b0);
        drive(1'b1, 32'hABCD, 32'h1, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        check("gate_m2r_data", W_WrData, 32'hABCD);
        check("gate_m2r_wren", W_WrEn, 1'b1);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        step();
        check("gate_cnt", W_RetireCnt, 16'(base_cnt + 3));

        // Stall and skid
        W_Stall = 1'b1;
        drive(1'b1, '0, 32'h10, 1'b0, 5'd2, 1'b1, 1'b0);
        step();
        drive(1'b1, '0, 32'h20, 1'b0, 5'd2, 1'b1, 1'b0);
        step();
        check("skid_ready_low", M_Ready, 1'b0);
        check("skid_hold_a", W_ALUout, 32'h10);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        step();
        check("skid_hold_a2", W_ALUout, 32'h10);
        W_Stall = 1'b0;
        step();
        check("skid_b_out", W_ALUout, 32'h20);
        check("skid_ready_back", M_Ready, 1'b1);
        step();
        check("skid_drained", W_Valid, 1'b0);

        // Flush with both entries full and an incoming beat
        W_Stall = 1'b1;
        drive(1'b1, '0, 32'h31, 1'b0, 5'd4, 1'b1, 1'b0);
        step();
        drive(1'b1, '0, 32'h32, 1'b0, 5'd4, 1'b1, 1'b0);
        step();
        base_cnt = W_RetireCnt;
        W_Stall = 1'b0;
        Flush = 1'b1;
        drive(1'b1, '0, 32'h99, 1'b0, 5'd4, 1'b1, 1'b0);
        step();
        Flush = 1'b0;
        check("flush_valid", W_Valid, 1'b0);
        check("flush_cnt", W_RetireCnt, 16'(base_cnt));
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("flush_no_99", (W_Valid && W_ALUout == 32'h99), 1'b0);
        end

        // Asynchronous reset mid-stream with both entries full
        W_Stall = 1'b1;
        drive(1'b1, '0, 32'h41, 1'b0, 5'd6, 1'b1, 1'b0);
        step();
        drive(1'b1, '0, 32'h42, 1'b0, 5'd6, 1'b1, 1'b0);
        step();
        check("pre_reset_full", M_Ready, 1'b0);
        #1;
        Reset = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        #1;
        check_reset_state("async_reset");
        W_Stall = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        step();
        Reset = 1'b0;

        // Counter wrap on the 4-bit instance: 17 consumed beats
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, '0, DATA_W'(k + 100), 1'b0, 5'd1, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        step();
        check("wrap_cnt4", s_w_cnt, 4'd1);
        check("wrap_cnt16", W_RetireCnt, 16'd17);

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            drive($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 9) == 0,
                  REG_AW'($urandom_range(0, 31)), $urandom_range(0, 1), $urandom_range(0, 1));
            W_Stall = $urandom_range(0, 9) < 3;
            Flush   = $urandom_range(0, 99) < 3;
            step();
        end
        Flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline stage with a valid/ready handshake, a one-entry skid buffer, flush, and write-enable qualification. It sits between the data-memory stage and register-file writeback. It replaces the plain always-load MEM/WB register so that the pipeline can stall and flush without losing or duplicating a writeback. It also produces a gated register-file write enable, the selected writeback data, and a retired-beat counter.

## Interface
- DATA_W, 32: width of the memory data and ALU result fields.
- REG_AW, 5: width of the destination register index.
- CNT_W, 16: width of the retired-beat counter.

- Clk  in  1  clock; all state updates occur on the falling edge of Clk.
- Reset  in  1  asynchronous, active-high reset.
- Flush  in  1  discard all buffered beats and drop any incoming beat on this edge.
- M_Valid  in  1  the upstream beat is valid.
- M_Ready  out  1  the stage can accept a beat; equals NOT skid_valid.
- M_Dout  in  DATA_W  data-memory read data.
- M_ALUout  in  DATA_W  ALU result.
- M_Overflow  in  1  ALU overflow flag.
- M_Rw  in  REG_AW  destination register index.
- M_RegWr, M_MemtoReg  in  1 each  control bits.
- W_Stall  in  1  writeback cannot consume the output beat this cycle.
- W_Valid  out  1  the output beat is valid.
- W_Dout, W_ALUout  out  DATA_W  registered copies of the input fields.
- W_Overflow, W_RegWr, W_MemtoReg  out  1 each  registered copies of the input fields.
- W_Rw  out  REG_AW  registered destination index.
- W_WrData  out  DATA_W  writeback data: W_Dout when W_MemtoReg is set, otherwise W_ALUout.
- W_WrEn  out  1  register-file write enable: W_Valid & W_RegWr & ~W_Overflow & (W_Rw != 0).
- W_RetireCnt  out  CNT_W  count of beats consumed.

## Operation
- Storage has two entries: a main entry, which drives the W_* outputs, and a skid entry. Each entry holds all fields plus a valid bit.
- accept = M_Valid & M_Ready. consume = W_Valid & ~W_Stall.
- Update priority at each falling edge:
  1. Reset, which is asynchronous.
  2. Flush.
  3. Normal operation.
- Reset: both valid bits = 0, all data and control fields = 0, W_RetireCnt = 0. As a result M_Ready = 1, W_Valid = 0, and W_WrEn = 0.
- Flush: both valid bits are cleared. The incoming beat is dropped even if M_Valid = 1. W_RetireCnt is unchanged. Field contents are don't-care, but the implementation clears them to 0.
- Normal operation, with the main entry empty: on accept, the input loads into the main entry. The skid entry is always empty in this state.
- Normal operation, with the main entry full and consume = 1:
  - If the skid entry is full, the skid entry moves into the main entry. The skid entry then becomes empty. M_Ready was 0, so there is no accept.
  - Otherwise, on accept, the input loads into the main entry.
  - Otherwise, the main entry becomes empty.
- Normal operation, with the main entry full and consume = 0: on accept, the input loads into the skid entry. The main entry holds.
- Ordering is strictly FIFO. No beat is lost or duplicated.
- W_RetireCnt increments by 1 on every consume and wraps from 2^CNT_W−1 to 0. There is no increment on a flush edge.
- W_WrEn and W_WrData are combinational from the main entry only. A beat with W_Rw = 0 or W_Overflow = 1 still retires and counts, but W_WrEn = 0.

## Timing
- Latency: a beat accepted at falling edge n appears on W_* immediately after edge n. If the main entry is occupied, the beat appears after the edge on which the preceding beat is consumed.
- Throughput: one beat per cycle when W_Stall = 0.
- M_Ready depends only on registered state. There is no combinational path from W_Stall to M_Ready.
- Asserting W_Stall for a single cycle costs one bubble-free skid: the beat is held in the skid entry and M_Ready drops for the next cycle.
- Reset asserted mid-operation clears everything immediately, regardless of Clk. The first accept can occur on the first falling edge after Reset deasserts.
- If Flush and consume are both asserted on the same edge, Flush wins and W_RetireCnt does not increment.
- If Flush and accept are both asserted on the same edge, the incoming beat is dropped.

## Test plan
- Reset: assert Reset mid-stream with both entries full. Required: W_Valid = 0, M_Ready = 1, W_WrEn = 0, all W_* fields = 0, and W_RetireCnt = 0 immediately, without waiting for a clock edge.
- Streaming: send beats with ALUout = 1,2,3,4, Rw = 3, RegWr = 1, MemtoReg = 0, and W_Stall = 0. Required: W_WrData = 1,2,3,4 on consecutive cycles, W_WrEn = 1 on each, and W_RetireCnt = 4.
- Stall and skid:
  - Send beats A = 0x10 and B = 0x20 back to back with W_Stall = 1 from the cycle A is accepted.
  - Required: M_Ready = 0 after B is accepted, and W_ALUout holds 0x10.
  - Then release W_Stall. Required: 0x10 then 0x20 appear on W_ALUout, and M_Ready = 1 again.
- Flush: with both entries full, assert Flush together with M_Valid = 1 and data 0x99. Required: W_Valid = 0 on the next cycle, 0x99 never appears, and W_RetireCnt is unchanged.
- Write-enable gating: send three beats, each with RegWr = 1:
  - Rw = 0. Required: W_WrEn = 0.
  - Overflow = 1 with Rw = 5. Required: W_WrEn = 0.
  - MemtoReg = 1 with Dout = 0xABCD and ALUout = 0x1. Required: W_WrData = 0xABCD and W_WrEn = 1.
  - Required for all three: W_RetireCnt increments by 3.
- Counter wrap: with CNT_W = 4, consume 17 beats. Required: W_RetireCnt = 1.
